// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand issue and writeback stage around an external 32-bit ALU
//
// Purpose:
//   Accepts decoded instructions over a valid/ready handshake, resolves operands
//   from an internal register file (with bypass from the in-flight result),
//   registers the ALU inputs (E stage), then retires the ALU result into the
//   register file and the wb_* registers (W stage).
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_in_valid / o_in_ready        instruction handshake (o_in_ready = !i_hold)
//   i_in_rd, i_in_rs1, i_in_rs2    destination / source register addresses
//   i_in_op, i_in_shift            ALU operation and left-shift amount
//   i_in_use_imm, i_in_imm         select zero-extended immediate as operand b
//   i_hold                         pipeline freeze
//   o_alu_a, o_alu_b, o_alu_op, o_alu_shift   registered ALU inputs
//   i_alu_out                      combinational ALU result
//   o_wb_valid, o_wb_rd, o_wb_data retired-result report
//   i_dbg_raddr / o_dbg_rdata      combinational register-file debug read

module alu_issue_stage #(
    parameter int NREG_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [NREG_W-1:0] i_in_rd,
    input  logic [NREG_W-1:0] i_in_rs1,
    input  logic [NREG_W-1:0] i_in_rs2,
    input  logic [1:0]        i_in_op,
    input  logic [3:0]        i_in_shift,
    input  logic              i_in_use_imm,
    input  logic [15:0]       i_in_imm,
    input  logic              i_hold,
    output logic [31:0]       o_alu_a,
    output logic [31:0]       o_alu_b,
    output logic [1:0]        o_alu_op,
    output logic [3:0]        o_alu_shift,
    input  logic [31:0]       i_alu_out,
    output logic              o_wb_valid,
    output logic [NREG_W-1:0] o_wb_rd,
    output logic [31:0]       o_wb_data,
    input  logic [NREG_W-1:0] i_dbg_raddr,
    output logic [31:0]       o_dbg_rdata
);

    localparam int NREG = 1 << NREG_W;

    logic [31:0]       r_rf [NREG];
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [1:0]        r_alu_op;
    logic [3:0]        r_alu_shift;
    logic [NREG_W-1:0] r_e_rd;
    logic              r_e_valid;
    logic              r_wb_valid;
    logic [NREG_W-1:0] r_wb_rd;
    logic [31:0]       r_wb_data;

    logic              w_accept;
    logic [31:0]       w_rs1_val;
    logic [31:0]       w_rs2_val;
    logic [31:0]       w_op_b;

    assign o_in_ready = !i_hold;
    assign w_accept   = i_in_valid && !i_hold;

    // Operand resolution. The in-flight E result is not yet in the register
    // file, so a matching source takes alu_out directly; r0 never bypasses
    // because a nonzero rs can only match a nonzero e_rd.
    always_comb begin
        w_rs1_val = 32'h0;
        if (i_in_rs1 != '0) begin
            if (r_e_valid && (r_e_rd == i_in_rs1)) begin
                w_rs1_val = i_alu_out;
            end else begin
                w_rs1_val = r_rf[i_in_rs1];
            end
        end
    end

    always_comb begin
        w_rs2_val = 32'h0;
        if (i_in_rs2 != '0) begin
            if (r_e_valid && (r_e_rd == i_in_rs2)) begin
                w_rs2_val = i_alu_out;
            end else begin
                w_rs2_val = r_rf[i_in_rs2];
            end
        end
    end

    assign w_op_b = i_in_use_imm ? {16'h0, i_in_imm} : w_rs2_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= 32'h0;
            end
            r_alu_a     <= 32'h0;
            r_alu_b     <= 32'h0;
            r_alu_op    <= 2'b00;
            r_alu_shift <= 4'h0;
            r_e_rd      <= '0;
            r_e_valid   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= 32'h0;
        end else if (i_hold) begin
            // Everything freezes except the retire strobe, which must not
            // repeat while the pipeline is stalled.
            r_wb_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a     <= w_rs1_val;
                r_alu_b     <= w_op_b;
                r_alu_op    <= i_in_op;
                r_alu_shift <= i_in_shift;
                r_e_rd      <= i_in_rd;
                r_e_valid   <= 1'b1;
            end else begin
                r_e_valid   <= 1'b0;
            end

            // Retirement is reported even for rd 0; only the write is dropped.
            if (r_e_valid) begin
                if (r_e_rd != '0) begin
                    r_rf[r_e_rd] <= i_alu_out;
                end
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_e_rd;
                r_wb_data  <= i_alu_out;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_alu_shift = r_alu_shift;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_rd     = r_wb_rd;
    assign o_wb_data   = r_wb_data;
    assign o_dbg_rdata = (i_dbg_raddr == '0) ? 32'h0 : r_rf[i_dbg_raddr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed table-driven bench for alu_issue_stage

module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd, in_rs1, in_rs2;
    logic [1:0]  in_op;
    logic [3:0]  in_shift;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic        hold;
    logic [31:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [3:0]  alu_shift;
    logic [31:0] alu_out;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_stage #(.NREG_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_rd(in_rd), .i_in_rs1(in_rs1), .i_in_rs2(in_rs2),
        .i_in_op(in_op), .i_in_shift(in_shift),
        .i_in_use_imm(in_use_imm), .i_in_imm(in_imm),
        .i_hold(hold),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_shift(alu_shift),
        .i_alu_out(alu_out),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: (a op b) << shift
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [3:0] sh);
        logic [31:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = a + b;
        endcase
        return r << sh;
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op, alu_shift);

    typedef struct {
        logic        v;
        logic [3:0]  rd, rs1, rs2;
        logic [1:0]  op;
        logic [3:0]  sh;
        logic        ui;
        logic [15:0] imm;
        logic [31:0] ea, eb;
        logic [1:0]  eop;
        logic [3:0]  esh;
        logic        ewv;
        logic [3:0]  erd;
        logic [31:0] ewd;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic v, input logic [3:0] rd, input logic [3:0] rs1,
                                input logic [3:0] rs2, input logic [1:0] op, input logic [3:0] sh,
                                input logic ui, input logic [15:0] imm,
                                input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] eop,
                                input logic [3:0] esh, input logic ewv, input logic [3:0] erd,
                                input logic [31:0] ewd);
        vec_t t;
        t.v = v; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.op = op; t.sh = sh;
        t.ui = ui; t.imm = imm; t.ea = ea; t.eb = eb; t.eop = eop; t.esh = esh;
        t.ewv = ewv; t.erd = erd; t.ewd = ewd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [1:0] op, input logic [3:0] sh,
                         input logic ui, input logic [15:0] imm);
        in_valid = v; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_op = op; in_shift = sh; in_use_imm = ui; in_imm = imm;
    endtask

    task automatic chk_alu(input string p, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [1:0] eop, input logic [3:0] esh);
        chk({p, " alu_a"}, alu_a, ea);
        chk({p, " alu_b"}, alu_b, eb);
        chk({p, " alu_op"}, 32'(alu_op), 32'(eop));
        chk({p, " alu_shift"}, 32'(alu_shift), 32'(esh));
    endtask

    task automatic chk_wb(input string p, input logic ewv, input logic [3:0] erd,
                          input logic [31:0] ewd);
        chk({p, " wb_valid"}, 32'(wb_valid), 32'(ewv));
        chk({p, " wb_rd"}, 32'(wb_rd), 32'(erd));
        chk({p, " wb_data"}, wb_data, ewd);
    endtask

    task automatic chk_dbg(input logic [3:0] a, input logic [31:0] exp);
        dbg_raddr = a;
        #1;
        chk($sformatf("dbg r%0d", a), dbg_rdata, exp);
    endtask

    logic [31:0] rf_exp [16];

    initial begin
        // valid rd rs1 rs2 op sh ui imm | alu_a alu_b op sh | wb_valid rd data
        tbl[0] = mk(1, 1, 0, 0, 3, 4, 1, 16'h1234, 32'h0,   32'h1234,  3, 4, 0, 0, 32'h0);
        tbl[1] = mk(1, 2, 0, 0, 1, 0, 1, 16'h00FF, 32'h0,   32'h00FF,  1, 0, 1, 1, 32'h12340);
        tbl[2] = mk(1, 3, 2, 0, 2, 0, 1, 16'h0F0F, 32'hFF,  32'h0F0F,  2, 0, 1, 2, 32'hFF);
        tbl[3] = mk(1, 0, 0, 0, 3, 0, 1, 16'h0005, 32'h0,   32'h5,     3, 0, 1, 3, 32'h0FF0);
        tbl[4] = mk(1, 5, 0, 3, 3, 0, 0, 16'h0000, 32'h0,   32'h0FF0,  3, 0, 1, 0, 32'h5);
        tbl[5] = mk(1, 6, 5, 1, 0, 1, 0, 16'h0000, 32'hFF0, 32'h12340, 0, 1, 1, 5, 32'hFF0);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 32'hFF0, 32'h12340, 0, 1, 1, 6, 32'h680);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 32'hFF0, 32'h12340, 0, 1, 0, 6, 32'h680);
        tbl[8] = mk(1, 7, 6, 3, 2, 0, 0, 16'h0000, 32'h680, 32'hFF0,   2, 0, 0, 6, 32'h680);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 32'h680, 32'hFF0,   2, 0, 1, 7, 32'h970);

        for (int i = 0; i < 16; i++) rf_exp[i] = 32'h0;
        rf_exp[1] = 32'h12340; rf_exp[2] = 32'hFF; rf_exp[3] = 32'h0FF0;
        rf_exp[5] = 32'hFF0;   rf_exp[6] = 32'h680; rf_exp[7] = 32'h970;

        rst_n = 1'b0;
        hold = 1'b0;
        dbg_raddr = 4'h0;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        for (int a = 0; a < 16; a++) chk_dbg(4'(a), 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk_wb("reset", 0, 0, 32'h0);
        chk_alu("reset", 32'h0, 32'h0, 2'd0, 4'd0);

        // Table: apply, clock, compare
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].op, tbl[i].sh,
                  tbl[i].ui, tbl[i].imm);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'h1);
            @(posedge clk); #1;
            chk_alu($sformatf("v%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop, tbl[i].esh);
            chk_wb($sformatf("v%0d", i), tbl[i].ewv, tbl[i].erd, tbl[i].ewd);
        end
        for (int a = 0; a < 16; a++) chk_dbg(4'(a), rf_exp[a]);

        // Hold for 3 cycles with r8 = imm 0x11 in E, r9 = imm 0x22 waiting
        drive(1, 8, 0, 0, 3, 0, 1, 16'h0011);
        @(posedge clk); #1;
        drive(1, 9, 0, 0, 3, 0, 1, 16'h0022);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("hold%0d wb_valid", k), 32'(wb_valid), 32'h0);
            chk($sformatf("hold%0d alu_b", k), alu_b, 32'h11);
        end
        chk_dbg(4'd8, 32'h0);
        hold = 1'b0;
        @(posedge clk); #1;
        chk_wb("release", 1, 8, 32'h11);
        chk("release alu_b", alu_b, 32'h22);
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        @(posedge clk); #1;
        chk_wb("post-release", 1, 9, 32'h22);
        @(posedge clk); #1;
        chk_wb("drain", 0, 9, 32'h22);
        chk_dbg(4'd8, 32'h11);
        chk_dbg(4'd9, 32'h22);

        // Reset with add r4 = imm 7 sitting in E
        drive(1, 4, 0, 0, 3, 0, 1, 16'h0007);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
        chk("pre-reset alu_b", alu_b, 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk_alu("in-reset", 32'h0, 32'h0, 2'd0, 4'd0);
        chk_wb("in-reset", 0, 0, 32'h0);
        chk("in-reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_wb("after-reset", 0, 0, 32'h0);
        chk_dbg(4'd4, 32'h0);
        chk_dbg(4'd1, 32'h0);
        chk_dbg(4'd9, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage wrapped around the 32-bit ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file, with bypass from the in-flight result. It drives registered `a`/`b`/`op`/`shift` into the ALU, then captures the ALU result and writes it back to the register file.

## Interface
- `NREG_W`, default 4: register-address width; the register file has 2^NREG_W entries of 32 bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: a decoded instruction is presented.
- `in_ready`  out  1: the stage accepts the instruction this cycle.
- `in_rd`  in  NREG_W: destination register.
- `in_rs1`  in  NREG_W: source register for operand a.
- `in_rs2`  in  NREG_W: source register for operand b.
- `in_op`  in  2: ALU operation (00 and, 01 or, 10 xor, 11 add).
- `in_shift`  in  4: left-shift amount applied by the ALU.
- `in_use_imm`  in  1: when 1, operand b is the immediate instead of rs2.
- `in_imm`  in  16: immediate, zero-extended to 32 bits.
- `hold`  in  1: pipeline freeze.
- `alu_a`, `alu_b`  out  32: registered ALU operands.
- `alu_op`  out  2: registered ALU operation.
- `alu_shift`  out  4: registered ALU shift amount.
- `alu_out`  in  32: combinational ALU result.
- `wb_valid`  out  1: a result was retired on the previous edge.
- `wb_rd`  out  NREG_W: register written by the retired result.
- `wb_data`  out  32: value written by the retired result.
- `dbg_raddr`  in  NREG_W: debug read address.
- `dbg_rdata`  out  32: combinational register-file read at `dbg_raddr`.

## Operation
- Two stages:
  - E (issue register: `alu_*`, `e_rd`, `e_valid`).
  - W (register-file write plus the `wb_*` registers).
- `in_ready = !hold`. A transfer occurs on a rising edge with `in_valid && in_ready`.
- Operand resolution happens combinationally in the accept cycle:
  - rs == 0 → 0. Register 0 always reads zero, and writes to it are discarded.
  - Else if `e_valid && e_rd == rs && e_rd != 0` → `alu_out` (bypass).
  - Else → `regfile[rs]`.
  - Operand b = `{16'h0, in_imm}` when `in_use_imm`; rs2 is ignored in that case.
- Accept edge: `alu_a`, `alu_b`, `alu_op`, `alu_shift` and `e_rd` load; `e_valid` is set.
- No transfer and not held: `e_valid` clears. The `alu_*` registers keep their last values.
- Edge with `e_valid && !hold`:
  - `regfile[e_rd] <= alu_out` (skipped when `e_rd == 0`).
  - `wb_valid <= 1`, `wb_rd <= e_rd`, `wb_data <= alu_out`.
  - This happens even for rd 0, so retirement stays observable.
- Any other edge: `wb_valid <= 0`. `wb_rd` and `wb_data` hold.
- `hold = 1`:
  - E registers, `e_valid` and the register file freeze.
  - No write occurs; `wb_valid <= 0`.
  - `in_ready = 0`, so no instruction is accepted.
- Retire and accept on the same edge: both happen. The new instruction's operands use the bypass value, so there is no stale read.
- `dbg_rdata` reflects the register-file contents only. It does not see the bypass; rd 0 reads 0.

## Timing
- Reset (async assert, sync release):
  - Register file cleared to 0.
  - `e_valid = 0`; `alu_a = alu_b = 0`; `alu_op = 0`; `alu_shift = 0`.
  - `wb_valid = 0`; `wb_rd = 0`; `wb_data = 0`.
  - `in_ready` follows `hold`.
- Latency for an instruction accepted at edge N:
  - `alu_*` valid from N to N+1.
  - Register write and `wb_*` update at edge N+1.
  - `wb_valid` high during cycle N+1..N+2.
- Throughput: one instruction per cycle while `hold = 0`. Dependent back-to-back instructions run with zero bubbles.
- Reset asserted mid-operation: the in-flight E instruction is discarded and never written back.
- Holding `hold` for k cycles delays retirement by exactly k cycles; no instruction is lost or duplicated.
- A dependency two or more instructions back is satisfied by the register file, since the write completed on an earlier edge.

## Test plan
- Reset, then read every `dbg_raddr` → all 0. Check `wb_valid = 0`, `in_ready = 1`, and all `alu_*` = 0.
- Issue `add r1 = r0 + imm 0x1234`, `shift = 4` → `alu_a = 0`, `alu_b = 0x1234` at N+1. Then `wb_valid = 1`, `wb_rd = 1`, `wb_data = 0x12340`, and `dbg r1 = 0x12340`.
- Back-to-back dependency: `r2 = r0 | imm 0x00FF`, then `r3 = r2 xor imm 0x0F0F` with no gap → second `alu_a = 0x00FF` via bypass; `r3 = 0x0FF0`.
- Write to r0 (`add imm 5`) → `wb_valid = 1`, `wb_rd = 0`, `wb_data = 5`. `dbg r0` still 0, and a following instruction reading r0 gets 0 with no bypass.
- Assert `hold` for 3 cycles with an instruction in E → `in_ready = 0`, no `wb_valid` during the hold. Retirement occurs on the first edge after release, with the correct data.
- Pulse `rst_n` low while E holds `add r4 = imm 7` → r4 stays 0, `wb_valid` stays 0, and all outputs return to their reset values.
